// File: rtl/imem_port_arbiter_if.sv
// Bundle of debugger, fetch and SRAM signals around the instruction-memory port arbiter.
// slave = arbiter side, master = surrounding debugger/fetch/SRAM environment.
interface imem_port_arbiter_if #(
  parameter int MEM_SIZE  = 16384,
  parameter int ADDR_SIZE = 40
);
  localparam int ADDR_W = $clog2(MEM_SIZE / 4);

  logic                 dbg_halt_i;
  logic                 dbg_halted_o;
  logic                 dbg_wr_valid_i;
  logic                 dbg_wr_ready_o;
  logic [ADDR_W-1:0]    dbg_addr_i;
  logic [31:0]          dbg_data_i;

  logic                 fetch_req_valid_i;
  logic                 fetch_req_ready_o;
  logic [ADDR_SIZE-1:0] fetch_req_addr_i;
  logic                 fetch_kill_i;
  logic                 fetch_resp_valid_o;
  logic [31:0]          fetch_resp_data_o;
  logic                 fetch_resp_xcpt_o;

  logic                 mem_en_o;
  logic                 mem_we_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [31:0]          mem_wdata_o;
  logic [31:0]          mem_rdata_i;

  modport slave (
    input  dbg_halt_i, dbg_wr_valid_i, dbg_addr_i, dbg_data_i,
    input  fetch_req_valid_i, fetch_req_addr_i, fetch_kill_i,
    input  mem_rdata_i,
    output dbg_halted_o, dbg_wr_ready_o,
    output fetch_req_ready_o, fetch_resp_valid_o, fetch_resp_data_o, fetch_resp_xcpt_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output dbg_halt_i, dbg_wr_valid_i, dbg_addr_i, dbg_data_i,
    output fetch_req_valid_i, fetch_req_addr_i, fetch_kill_i,
    output mem_rdata_i,
    input  dbg_halted_o, dbg_wr_ready_o,
    input  fetch_req_ready_o, fetch_resp_valid_o, fetch_resp_data_o, fetch_resp_xcpt_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a 1-cycle single-port instruction SRAM between debugger writes and fetch reads, with halt/drain.
// Fetch response exactly 1 cycle after grant, no response backpressure; debugger burst is bounded so fetch progresses.
module imem_port_arbiter #(
  parameter int MEM_SIZE      = 16384,
  parameter int ADDR_SIZE     = 40,
  parameter int MAX_DBG_BURST = 8
) (
  input logic               clk_i,
  input logic               rstn_i,
  imem_port_arbiter_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_SIZE / 4);
  localparam int CNT_W  = $clog2(MAX_DBG_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DBG_BURST);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               pend_rd_q, pend_rd_d;
  logic               pend_xcpt_q, pend_xcpt_d;
  logic               halted_q, halted_d;

  logic               fetch_ok;
  logic               fetch_fault;
  logic               dbg_gnt;
  logic               fetch_gnt;
  logic [ADDR_SIZE-1:0] fetch_addr;

  // Grants are gated by the reset pin itself so nothing reaches the SRAM while reset is held.
  always_comb begin
    fetch_addr  = bus.fetch_req_addr_i;
    fetch_fault = ((fetch_addr >> (ADDR_W + 2)) != '0) || (fetch_addr[1:0] != 2'b00);
    fetch_ok    = rstn_i && (state_q == ST_RUN) && !bus.dbg_halt_i &&
                  bus.fetch_req_valid_i && !bus.fetch_kill_i;
    dbg_gnt     = rstn_i && bus.dbg_wr_valid_i && (!fetch_ok || (burst_cnt_q < BURST_MAX));
    fetch_gnt   = fetch_ok && !dbg_gnt;
  end

  always_comb begin
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (dbg_gnt) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_we_o    = 1'b1;
      bus.mem_addr_o  = bus.dbg_addr_i;
      bus.mem_wdata_o = bus.dbg_data_i;
    end else if (fetch_gnt && !fetch_fault) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_addr_o = fetch_addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.dbg_halt_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.dbg_halt_i)  state_d = ST_RUN;
        else if (!pend_rd_q)  state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!bus.dbg_halt_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Only consecutive debugger wins against a waiting fetch count towards the burst limit.
    burst_cnt_d = '0;
    if (dbg_gnt && fetch_ok) begin
      burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + CNT_W'(1);
    end

    pend_rd_d   = fetch_gnt && !fetch_fault;
    pend_xcpt_d = fetch_gnt && fetch_fault;
    halted_d    = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_RUN;
      burst_cnt_q <= '0;
      pend_rd_q   <= 1'b0;
      pend_xcpt_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      pend_rd_q   <= pend_rd_d;
      pend_xcpt_q <= pend_xcpt_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.dbg_wr_ready_o     = dbg_gnt;
  assign bus.fetch_req_ready_o  = fetch_gnt;
  assign bus.dbg_halted_o       = halted_q;
  assign bus.fetch_resp_valid_o = (pend_rd_q || pend_xcpt_q) && !bus.fetch_kill_i;
  assign bus.fetch_resp_data_o  = pend_rd_q ? bus.mem_rdata_i : 32'h0;
  assign bus.fetch_resp_xcpt_o  = pend_xcpt_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_imem_port_arbiter;
  localparam int MEM_SIZE      = 16384;
  localparam int ADDR_SIZE     = 40;
  localparam int MAX_DBG_BURST = 8;
  localparam int ADDR_W        = 12;
  localparam int NWORDS        = MEM_SIZE / 4;

  logic clk_i = 1'b0;
  logic rstn_i;
  int   checks   = 0;
  int   failures = 0;

  imem_port_arbiter_if #(.MEM_SIZE(MEM_SIZE), .ADDR_SIZE(ADDR_SIZE)) bus ();

  imem_port_arbiter #(
    .MEM_SIZE(MEM_SIZE), .ADDR_SIZE(ADDR_SIZE), .MAX_DBG_BURST(MAX_DBG_BURST)
  ) dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // SRAM macro stand-in: 1-cycle read latency
  bit [31:0] sram [NWORDS];
  always @(posedge clk_i) begin
    if (bus.mem_en_o === 1'b1) begin
      if (bus.mem_we_o === 1'b1) sram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else                       bus.mem_rdata_i <= sram[bus.mem_addr_o];
    end
  end

  // Reference model: memory image, waiting-fetch debug streak, halt history, expected response
  bit [31:0]       gold [NWORDS];
  int              m_streak;
  bit              m_h1, m_h2;
  bit              m_pv, m_pf;
  bit [31:0]       m_pd;
  bit              e_drdy, e_frdy, e_en, e_we, e_rv, e_rx, e_halted, e_fault, e_fok;
  bit [ADDR_W-1:0] e_addr, e_fword;
  bit [31:0]       e_wdata, e_rd;

  task automatic model_reset();
    m_streak = 0; m_h1 = 0; m_h2 = 0; m_pv = 0; m_pf = 0; m_pd = 0;
  endtask

  task automatic model_eval();
    logic [ADDR_SIZE-1:0] fa;
    bit run;
    fa       = bus.fetch_req_addr_i;
    e_fault  = (fa >= MEM_SIZE) || (fa % 4 != 0);
    e_fword  = ADDR_W'(fa >> 2);
    run      = !m_h1;
    e_fok    = run && !bus.dbg_halt_i && bus.fetch_req_valid_i && !bus.fetch_kill_i;
    e_drdy   = bus.dbg_wr_valid_i && (!e_fok || m_streak < MAX_DBG_BURST);
    e_frdy   = e_fok && !e_drdy;
    e_en     = e_drdy || (e_frdy && !e_fault);
    e_we     = e_drdy;
    e_addr   = e_drdy ? bus.dbg_addr_i : ((e_frdy && !e_fault) ? e_fword : '0);
    e_wdata  = e_drdy ? bus.dbg_data_i : 32'h0;
    e_rv     = m_pv && !bus.fetch_kill_i;
    e_rx     = m_pv && m_pf;
    e_rd     = m_pd;
    e_halted = m_h1 && m_h2;
  endtask

  task automatic model_commit();
    if (e_drdy) gold[bus.dbg_addr_i] = bus.dbg_data_i;
    m_streak = (e_drdy && e_fok) ? ((m_streak < MAX_DBG_BURST) ? m_streak + 1 : MAX_DBG_BURST) : 0;
    m_pv = e_frdy;
    m_pf = e_fault;
    m_pd = (e_frdy && !e_fault) ? gold[e_fword] : 32'h0;
    m_h2 = m_h1;
    m_h1 = bus.dbg_halt_i;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic drive(input bit dv, input bit [ADDR_W-1:0] da, input bit [31:0] dd,
                       input bit fv, input logic [ADDR_SIZE-1:0] fa, input bit kill, input bit halt);
    bus.dbg_wr_valid_i    = dv;
    bus.dbg_addr_i        = da;
    bus.dbg_data_i        = dd;
    bus.fetch_req_valid_i = fv;
    bus.fetch_req_addr_i  = fa;
    bus.fetch_kill_i      = kill;
    bus.dbg_halt_i        = halt;
    #1;
    model_eval();
  endtask

  task automatic idle();
    drive(1'b0, '0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic adv();
    model_commit();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    model_reset();
    drive(1'b1, 12'd7, 32'hDEAD_BEEF, 1'b1, 40'h10, 1'b0, 1'b0);
    @(negedge clk_i); #1;
    checks++; if (bus.mem_en_o !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== 12'h0 || bus.mem_wdata_o !== 32'h0) begin failures++; $display("FAIL rst_mem_bus addr=%h wdata=%h exp=0", bus.mem_addr_o, bus.mem_wdata_o); end
    checks++; if (bus.dbg_wr_ready_o !== 1'b0 || bus.fetch_req_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready dbg=%b fetch=%b exp=0", bus.dbg_wr_ready_o, bus.fetch_req_ready_o); end
    checks++; if (bus.fetch_resp_valid_o !== 1'b0 || bus.fetch_resp_xcpt_o !== 1'b0 || bus.fetch_resp_data_o !== 32'h0) begin failures++; $display("FAIL rst_resp v=%b x=%b d=%h exp=0", bus.fetch_resp_valid_o, bus.fetch_resp_xcpt_o, bus.fetch_resp_data_o); end
    checks++; if (bus.dbg_halted_o !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", bus.dbg_halted_o); end
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    model_eval();
    checks++; if (bus.dbg_wr_ready_o !== 1'b1 || bus.mem_en_o !== 1'b1) begin failures++; $display("FAIL rel_first_grant rdy=%b en=%b exp=1", bus.dbg_wr_ready_o, bus.mem_en_o); end
    checks++; if (bus.fetch_req_ready_o !== 1'b0) begin failures++; $display("FAIL rel_fetch_blocked got=%b exp=0", bus.fetch_req_ready_o); end
    adv();
  endtask

  task automatic test_raw();
    drive(1'b1, 12'd5, 32'h0000_0013, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (bus.dbg_wr_ready_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_en_o !== 1'b1) begin failures++; $display("FAIL raw_wr_grant rdy=%b en=%b we=%b exp=111", bus.dbg_wr_ready_o, bus.mem_en_o, bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== 12'd5 || bus.mem_wdata_o !== 32'h13) begin failures++; $display("FAIL raw_wr_bus addr=%h wdata=%h exp=5/13", bus.mem_addr_o, bus.mem_wdata_o); end
    adv();
    drive(1'b0, '0, 32'h0, 1'b1, 40'h14, 1'b0, 1'b0);
    checks++; if (bus.fetch_req_ready_o !== 1'b1 || bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin failures++; $display("FAIL raw_rd_grant rdy=%b en=%b we=%b exp=110", bus.fetch_req_ready_o, bus.mem_en_o, bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== 12'd5) begin failures++; $display("FAIL raw_rd_addr got=%h exp=5", bus.mem_addr_o); end
    adv();
    idle();
    checks++; if (bus.fetch_resp_valid_o !== 1'b1 || bus.fetch_resp_xcpt_o !== 1'b0) begin failures++; $display("FAIL raw_resp v=%b x=%b exp=1/0", bus.fetch_resp_valid_o, bus.fetch_resp_xcpt_o); end
    checks++; if (bus.fetch_resp_data_o !== 32'h0000_0013) begin failures++; $display("FAIL raw_resp_data got=%h exp=00000013", bus.fetch_resp_data_o); end
    adv();
  endtask

  task automatic test_burst();
    bit exp_d;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 12'($urandom_range(64, NWORDS - 1)), $urandom, 1'b1,
            40'($urandom_range(64, NWORDS - 1)) << 2, 1'b0, 1'b0);
      exp_d = (i % 9) != 8;
      checks++; if (bus.dbg_wr_ready_o !== exp_d || bus.fetch_req_ready_o !== !exp_d) begin failures++; $display("FAIL burst_pattern cyc=%0d dbg=%b fetch=%b exp_dbg=%b", i, bus.dbg_wr_ready_o, bus.fetch_req_ready_o, exp_d); end
      checks++; if (bus.fetch_resp_valid_o !== (i == 9 || i == 18)) begin failures++; $display("FAIL burst_resp cyc=%0d got=%b", i, bus.fetch_resp_valid_o); end
      adv();
    end
    idle();
    adv();
  endtask

  task automatic test_fault();
    logic [ADDR_SIZE-1:0] addrs [2];
    addrs[0] = 40'h4000;
    addrs[1] = 40'h2;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 32'h0, 1'b1, addrs[i], 1'b0, 1'b0);
      checks++; if (bus.fetch_req_ready_o !== 1'b1 || bus.mem_en_o !== 1'b0) begin failures++; $display("FAIL fault_grant addr=%h rdy=%b en=%b exp=1/0", addrs[i], bus.fetch_req_ready_o, bus.mem_en_o); end
      adv();
      idle();
      checks++; if (bus.fetch_resp_valid_o !== 1'b1 || bus.fetch_resp_xcpt_o !== 1'b1 || bus.fetch_resp_data_o !== 32'h0) begin failures++; $display("FAIL fault_resp addr=%h v=%b x=%b d=%h exp=1/1/0", addrs[i], bus.fetch_resp_valid_o, bus.fetch_resp_xcpt_o, bus.fetch_resp_data_o); end
      adv();
    end
  endtask

  task automatic test_halt();
    drive(1'b0, '0, 32'h0, 1'b1, 40'h14, 1'b0, 1'b0);
    checks++; if (bus.fetch_req_ready_o !== 1'b1) begin failures++; $display("FAIL halt_pre_grant got=%b exp=1", bus.fetch_req_ready_o); end
    adv();
    drive(1'b0, '0, 32'h0, 1'b1, 40'h18, 1'b0, 1'b1);
    checks++; if (bus.fetch_resp_valid_o !== 1'b1 || bus.fetch_resp_data_o !== 32'h13) begin failures++; $display("FAIL halt_drain_resp v=%b d=%h exp=1/13", bus.fetch_resp_valid_o, bus.fetch_resp_data_o); end
    checks++; if (bus.fetch_req_ready_o !== 1'b0 || bus.dbg_halted_o !== 1'b0) begin failures++; $display("FAIL halt_c1 rdy=%b halted=%b exp=0/0", bus.fetch_req_ready_o, bus.dbg_halted_o); end
    adv();
    drive(1'b1, 12'd9, 32'h0000_A5A5, 1'b1, 40'h18, 1'b0, 1'b1);
    checks++; if (bus.fetch_req_ready_o !== 1'b0 || bus.dbg_wr_ready_o !== 1'b1 || bus.dbg_halted_o !== 1'b0) begin failures++; $display("FAIL halt_c2 frdy=%b drdy=%b halted=%b exp=0/1/0", bus.fetch_req_ready_o, bus.dbg_wr_ready_o, bus.dbg_halted_o); end
    adv();
    drive(1'b1, 12'd10, 32'h0000_5A5A, 1'b1, 40'h18, 1'b0, 1'b1);
    checks++; if (bus.dbg_halted_o !== 1'b1 || bus.fetch_req_ready_o !== 1'b0 || bus.dbg_wr_ready_o !== 1'b1) begin failures++; $display("FAIL halt_c3 halted=%b frdy=%b drdy=%b exp=1/0/1", bus.dbg_halted_o, bus.fetch_req_ready_o, bus.dbg_wr_ready_o); end
    adv();
    drive(1'b0, '0, 32'h0, 1'b1, 40'h24, 1'b0, 1'b0);
    checks++; if (bus.fetch_req_ready_o !== 1'b0 || bus.dbg_halted_o !== 1'b1) begin failures++; $display("FAIL halt_release_c0 frdy=%b halted=%b exp=0/1", bus.fetch_req_ready_o, bus.dbg_halted_o); end
    adv();
    drive(1'b0, '0, 32'h0, 1'b1, 40'h24, 1'b0, 1'b0);
    checks++; if (bus.fetch_req_ready_o !== 1'b1 || bus.dbg_halted_o !== 1'b0) begin failures++; $display("FAIL halt_release_c1 frdy=%b halted=%b exp=1/0", bus.fetch_req_ready_o, bus.dbg_halted_o); end
    adv();
    idle();
    checks++; if (bus.fetch_resp_valid_o !== 1'b1 || bus.fetch_resp_data_o !== 32'h0000_A5A5) begin failures++; $display("FAIL halt_written_word v=%b d=%h exp=1/0000a5a5", bus.fetch_resp_valid_o, bus.fetch_resp_data_o); end
    adv();
  endtask

  task automatic test_kill();
    drive(1'b0, '0, 32'h0, 1'b1, 40'h14, 1'b0, 1'b0);
    adv();
    drive(1'b0, '0, 32'h0, 1'b1, 40'h14, 1'b1, 1'b0);
    checks++; if (bus.fetch_resp_valid_o !== 1'b0 || bus.fetch_req_ready_o !== 1'b0) begin failures++; $display("FAIL kill_c1 v=%b rdy=%b exp=0/0", bus.fetch_resp_valid_o, bus.fetch_req_ready_o); end
    adv();
    idle();
    checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin failures++; $display("FAIL kill_c2 v=%b exp=0", bus.fetch_resp_valid_o); end
    adv();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1'b0, '0, 32'h0, 1'b1, 40'(i * 4), 1'b0, 1'b0);
      else       idle();
      if (i < 6) begin
        checks++; if (bus.fetch_req_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_grant i=%0d got=%b exp=1", i, bus.fetch_req_ready_o); end
      end
      if (i > 0) begin
        checks++; if (bus.fetch_resp_valid_o !== 1'b1 || bus.fetch_resp_data_o !== gold[i-1]) begin failures++; $display("FAIL b2b_resp i=%0d v=%b d=%h exp=1/%h", i, bus.fetch_resp_valid_o, bus.fetch_resp_data_o, gold[i-1]); end
      end
      adv();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 32'h0, 1'b1, 40'h14, 1'b0, 1'b0);
    adv();
    #1;
    checks++; if (bus.fetch_resp_valid_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre v=%b exp=1", bus.fetch_resp_valid_o); end
    rstn_i = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.fetch_resp_valid_o !== 1'b0 || bus.mem_en_o !== 1'b0 || bus.fetch_req_ready_o !== 1'b0) begin failures++; $display("FAIL rstmid_drop v=%b en=%b rdy=%b exp=0", bus.fetch_resp_valid_o, bus.mem_en_o, bus.fetch_req_ready_o); end
    @(negedge clk_i);
    rstn_i = 1'b1;
    idle();
    checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_after0 v=%b exp=0", bus.fetch_resp_valid_o); end
    adv();
    idle();
    checks++; if (bus.fetch_resp_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_after1 v=%b exp=0", bus.fetch_resp_valid_o); end
    adv();
  endtask

  task automatic test_random();
    bit dv, fv, kill, halt;
    logic [ADDR_SIZE-1:0] fa;
    halt = 1'b0;
    for (int i = 0; i < 800; i++) begin
      dv   = $urandom_range(0, 99) < 55;
      fv   = $urandom_range(0, 99) < 75;
      kill = $urandom_range(0, 99) < 8;
      if ($urandom_range(0, 99) < 6) halt = !halt;
      if ($urandom_range(0, 99) < 85) fa = 40'($urandom_range(0, NWORDS - 1)) << 2;
      else                            fa = (40'($urandom) << 2) | 40'($urandom_range(0, 3));
      drive(dv, 12'($urandom_range(0, NWORDS - 1)), $urandom, fv, fa, kill, halt);
      checks++; if (bus.dbg_wr_ready_o !== e_drdy) begin failures++; $display("FAIL rnd_dbg_rdy cyc=%0d got=%b exp=%b", i, bus.dbg_wr_ready_o, e_drdy); end
      checks++; if (bus.fetch_req_ready_o !== e_frdy) begin failures++; $display("FAIL rnd_fetch_rdy cyc=%0d got=%b exp=%b", i, bus.fetch_req_ready_o, e_frdy); end
      checks++; if (bus.mem_en_o !== e_en || bus.mem_we_o !== e_we) begin failures++; $display("FAIL rnd_mem_ctl cyc=%0d en=%b we=%b exp=%b/%b", i, bus.mem_en_o, bus.mem_we_o, e_en, e_we); end
      checks++; if (bus.mem_addr_o !== e_addr || bus.mem_wdata_o !== e_wdata) begin failures++; $display("FAIL rnd_mem_bus cyc=%0d addr=%h wdata=%h exp=%h/%h", i, bus.mem_addr_o, bus.mem_wdata_o, e_addr, e_wdata); end
      checks++; if (bus.fetch_resp_valid_o !== e_rv || bus.fetch_resp_xcpt_o !== e_rx) begin failures++; $display("FAIL rnd_resp cyc=%0d v=%b x=%b exp=%b/%b", i, bus.fetch_resp_valid_o, bus.fetch_resp_xcpt_o, e_rv, e_rx); end
      checks++; if (bus.fetch_resp_data_o !== e_rd) begin failures++; $display("FAIL rnd_resp_data cyc=%0d got=%h exp=%h", i, bus.fetch_resp_data_o, e_rd); end
      checks++; if (bus.dbg_halted_o !== e_halted) begin failures++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", i, bus.dbg_halted_o, e_halted); end
      adv();
    end
    idle();
    adv();
  endtask

  initial begin
    rstn_i = 1'b0;
    bus.dbg_halt_i        = 1'b0;
    bus.dbg_wr_valid_i    = 1'b0;
    bus.dbg_addr_i        = '0;
    bus.dbg_data_i        = '0;
    bus.fetch_req_valid_i = 1'b0;
    bus.fetch_req_addr_i  = '0;
    bus.fetch_kill_i      = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_raw();
    test_burst();
    test_fault();
    test_halt();
    test_kill();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
